attn_v_spike_mac_engine: RTL and testbench

//  Parametrised Attn @ V engine for the spiking-transformer attention head. Per query row i
//  and channel c it computes psum[t] = sum_j A[i][j][t] * V[j][c][t] over one row of a

---
 rtl/attn_v_spike_mac_engine.sv | 179 +++++++++++++++++
 tb/tb_attn_v_spike_mac_engine.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_v_spike_mac_engine.sv
// Attn @ V spike engine: accumulates one score row against binary value spikes,
// then runs a hard-reset LIF per channel and hands out one spike row per query.
module attn_v_spike_mac_engine #(
  parameter int  N_TOK      = 64,
  parameter int  CHNLS      = 32,
  parameter int  TIME_STEPS = 4,
  parameter int  ATTN_W     = 6,
  localparam int ACC_W      = ATTN_W + $clog2(N_TOK),
  localparam int AW         = $clog2(N_TOK * N_TOK),
  localparam int VW         = $clog2(N_TOK),
  localparam int SW         = CHNLS * TIME_STEPS
) (
  input  logic                         s_clk,
  input  logic                         s_rst,
  input  logic                         i_start,
  input  logic                         i_causal,
  input  logic [ACC_W-1:0]             i_thrd,
  output logic                         o_busy,
  output logic [AW-1:0]                o_attn_rd_addr,
  input  logic [ATTN_W*TIME_STEPS-1:0] i_attn_rd_data,
  output logic [VW-1:0]                o_v_rd_addr,
  input  logic [SW-1:0]                i_v_rd_data,
  output logic [SW-1:0]                o_spk_data,
  output logic [VW-1:0]                o_spk_row,
  output logic                         o_spk_valid,
  input  logic                         i_spk_ready,
  output logic                         o_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    FIRE  = 3'd3,
    OUT   = 3'd4,
    FIN   = 3'd5
  } state_e;

  localparam logic [VW-1:0] LAST_IDX = VW'(N_TOK - 1);

  state_e           state_q, state_d;
  logic             causal_q;
  logic [ACC_W-1:0] thr_q;
  logic [VW-1:0]    row_q;
  logic [VW-1:0]    col_q;
  logic             rd_vld_q;
  logic [ACC_W-1:0] acc_q [CHNLS][TIME_STEPS];
  logic [SW-1:0]    spk_s;
  logic [ACC_W:0]   m_s;
  logic             last_col_s;
  logic             last_row_s;
  logic             enter_read_s;

  // Causal rows stop at the diagonal column j == i
  assign last_col_s   = causal_q ? (col_q == row_q) : (col_q == LAST_IDX);
  assign last_row_s   = (row_q == LAST_IDX);
  assign enter_read_s = (state_d == READ) && (state_q != READ);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_start) state_d = READ; else state_d = IDLE;
      READ:    if (last_col_s) state_d = DRAIN; else state_d = READ;
      DRAIN:   state_d = FIRE;
      FIRE:    state_d = OUT;
      OUT: begin
        if (i_spk_ready) begin
          if (last_row_s) state_d = FIN; else state_d = READ;
        end else begin
          state_d = OUT;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, configuration latch, row/column counters and RAM read addresses
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      state_q        <= IDLE;
      causal_q       <= 1'b0;
      thr_q          <= '0;
      row_q          <= '0;
      col_q          <= '0;
      rd_vld_q       <= 1'b0;
      o_attn_rd_addr <= '0;
      o_v_rd_addr    <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= (state_q == READ);
      case (state_q)
        IDLE: begin
          if (i_start) begin
            causal_q       <= i_causal;
            thr_q          <= i_thrd;
            row_q          <= '0;
            col_q          <= '0;
            o_attn_rd_addr <= '0;
            o_v_rd_addr    <= '0;
          end
        end
        READ: begin
          if (!last_col_s) begin
            col_q          <= col_q + VW'(1);
            o_attn_rd_addr <= o_attn_rd_addr + AW'(1);
            o_v_rd_addr    <= col_q + VW'(1);
          end
        end
        OUT: begin
          if (i_spk_ready && !last_row_s) begin
            row_q          <= row_q + VW'(1);
            col_q          <= '0;
            o_attn_rd_addr <= AW'((32'(row_q) + 32'd1) * 32'(N_TOK));
            o_v_rd_addr    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Accumulators: cleared entering READ, fed by the beat returned one cycle after each address
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      for (int c = 0; c < CHNLS; c++)
        for (int t = 0; t < TIME_STEPS; t++)
          acc_q[c][t] <= '0;
    end else if (enter_read_s) begin
      for (int c = 0; c < CHNLS; c++)
        for (int t = 0; t < TIME_STEPS; t++)
          acc_q[c][t] <= '0;
    end else if (rd_vld_q) begin
      for (int c = 0; c < CHNLS; c++)
        for (int t = 0; t < TIME_STEPS; t++)
          if (i_v_rd_data[c*TIME_STEPS+t])
            acc_q[c][t] <= acc_q[c][t] + ACC_W'(i_attn_rd_data[ATTN_W*t +: ATTN_W]);
    end
  end

  // LIF: membrane carries across time steps within a channel, hard reset on fire
  always_comb begin
    spk_s = '0;
    m_s   = '0;
    for (int c = 0; c < CHNLS; c++) begin
      m_s = '0;
      for (int t = 0; t < TIME_STEPS; t++) begin
        m_s = m_s + {1'b0, acc_q[c][t]};
        if (m_s >= {1'b0, thr_q}) begin
          spk_s[c*TIME_STEPS+t] = 1'b1;
          m_s                   = '0;
        end else begin
          spk_s[c*TIME_STEPS+t] = 1'b0;
        end
      end
    end
  end

  // Registered outputs: spike row capture in FIRE, handshake valid, busy and done
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      o_busy      <= 1'b0;
      o_spk_valid <= 1'b0;
      o_done      <= 1'b0;
      o_spk_data  <= '0;
      o_spk_row   <= '0;
    end else begin
      o_busy      <= (state_d != IDLE);
      o_spk_valid <= (state_d == OUT);
      o_done      <= (state_d == FIN);
      if (state_q == FIRE) begin
        o_spk_data <= spk_s;
        o_spk_row  <= row_q;
      end
    end
  end

endmodule

// File: tb/tb_attn_v_spike_mac_engine.sv
// Scoreboard bench for attn_v_spike_mac_engine: expected rows come from a plain
// arithmetic model of psum + LIF and are popped by a monitor on each handshake.
`timescale 1ns/1ps
module tb_attn_v_spike_mac_engine;
  localparam int N     = 64;
  localparam int C     = 32;
  localparam int T     = 4;
  localparam int AWD   = 6;
  localparam int ACC_W = AWD + $clog2(N);
  localparam int AAW   = $clog2(N * N);
  localparam int VW    = $clog2(N);
  localparam int SW    = C * T;

  logic             s_clk = 1'b0;
  logic             s_rst;
  logic             i_start;
  logic             i_causal;
  logic [ACC_W-1:0] i_thrd;
  logic             o_busy;
  logic [AAW-1:0]   o_attn_rd_addr;
  logic [AWD*T-1:0] i_attn_rd_data;
  logic [VW-1:0]    o_v_rd_addr;
  logic [SW-1:0]    i_v_rd_data;
  logic [SW-1:0]    o_spk_data;
  logic [VW-1:0]    o_spk_row;
  logic             o_spk_valid;
  logic             i_spk_ready;
  logic             o_done;

  attn_v_spike_mac_engine dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_start(i_start), .i_causal(i_causal),
    .i_thrd(i_thrd), .o_busy(o_busy), .o_attn_rd_addr(o_attn_rd_addr),
    .i_attn_rd_data(i_attn_rd_data), .o_v_rd_addr(o_v_rd_addr),
    .i_v_rd_data(i_v_rd_data), .o_spk_data(o_spk_data), .o_spk_row(o_spk_row),
    .o_spk_valid(o_spk_valid), .i_spk_ready(i_spk_ready), .o_done(o_done)
  );

  always #5 s_clk = ~s_clk;

  logic [AWD*T-1:0] attn_mem [N*N];
  logic [SW-1:0]    v_mem    [N];

  // Synchronous-read RAMs with one cycle of latency
  always @(posedge s_clk) begin
    i_attn_rd_data <= attn_mem[o_attn_rd_addr];
    i_v_rd_data    <= v_mem[o_v_rd_addr];
  end

  typedef struct {
    int            row;
    logic [SW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            checks = 0;
  int            errors = 0;
  int            busy_cyc = 0;
  int            exp_lat = 0;
  int            done_cnt = 0;
  int            stall_cnt = 0;
  bit            done_seen = 0;
  bit            first_seen = 1;
  bit            holding = 0;
  bit            stall_mode = 0;
  bit            rand_ready = 0;
  logic [SW-1:0] held_data;
  logic [VW-1:0] held_row;
  logic [AAW-1:0] held_aaddr;
  logic [VW-1:0] held_vaddr;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: psum[t] = sum over allowed j of A[i][j][t]*V[j][c][t], then hard-reset LIF
  function automatic logic [SW-1:0] ref_row(input int i, input bit causal, input int thr);
    logic [SW-1:0] r;
    int len, psum, m;
    len = causal ? i + 1 : N;
    r = '0;
    for (int c = 0; c < C; c++) begin
      m = 0;
      for (int t = 0; t < T; t++) begin
        psum = 0;
        for (int j = 0; j < len; j++)
          if (v_mem[j][c*T+t]) psum += int'(attn_mem[i*N+j][t*AWD +: AWD]);
        m += psum;
        if (m >= thr) begin
          r[c*T+t] = 1'b1;
          m = 0;
        end
      end
    end
    return r;
  endfunction

  // a_mode: 0 random scores, 1 all ones. v_mode: 0 zeros, 1 ones, 2 random
  task automatic fill(input int a_mode, input int v_mode);
    for (int k = 0; k < N*N; k++)
      for (int t = 0; t < T; t++)
        attn_mem[k][t*AWD +: AWD] = (a_mode == 1) ? 6'd1 : 6'($urandom_range(0, 63));
    for (int j = 0; j < N; j++)
      for (int b = 0; b < SW; b++)
        v_mem[j][b] = (v_mode == 0) ? 1'b0 : (v_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic start_pass(input bit causal, input int thr);
    for (int i = 0; i < N; i++) exp_q.push_back('{i, ref_row(i, causal, thr)});
    exp_lat    = causal ? 4 : N + 3;
    first_seen = 0;
    done_seen  = 0;
    done_cnt   = 0;
    holding    = 0;
    @(posedge s_clk); #1;
    i_causal = causal;
    i_thrd   = thr[ACC_W-1:0];
    i_start  = 1'b1;
    @(posedge s_clk); #1;
    i_start  = 1'b0;
    i_causal = ~causal;
    i_thrd   = ~i_thrd;
  endtask

  task automatic finish_pass(input string tag);
    for (int k = 0; k < 30000 && !done_seen; k++) begin
      @(posedge s_clk); #1;
      i_start = (k == 50);
    end
    i_start = 1'b0;
    checks++;
    if (!done_seen) begin
      errors++;
      $display("FAIL pass_timeout %s: got no o_done, expected o_done within 30000 cycles", tag);
    end
    @(negedge s_clk);
    check({"busy_after_done ", tag}, o_busy, 0);
    check({"done_one_cycle ", tag}, o_done, 0);
    check({"done_pulses ", tag}, done_cnt, 1);
    exp_q.delete();
  endtask

  task automatic run_pass(input bit causal, input int thr, input string tag);
    start_pass(causal, thr);
    finish_pass(tag);
  endtask

  // Downstream ready: always, random, or a 10-cycle stall on row 5
  initial begin
    i_spk_ready = 1'b1;
    forever begin
      @(posedge s_clk); #1;
      if (stall_mode && o_spk_valid && o_spk_row == 6'd5 && stall_cnt < 10) begin
        i_spk_ready = 1'b0;
        stall_cnt++;
      end else if (rand_ready) begin
        i_spk_ready = ($urandom_range(0, 3) != 0);
      end else begin
        i_spk_ready = 1'b1;
      end
    end
  end

  // Monitor: latency of the first row, hold stability under back-pressure, scoreboard pop
  always @(negedge s_clk) begin
    if (!s_rst) begin
      if (o_busy) busy_cyc++; else busy_cyc = 0;
      if (o_spk_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          check("first_row_latency", busy_cyc, exp_lat);
        end
        if (holding) begin
          check("hold_data", o_spk_data, held_data);
          check("hold_row", o_spk_row, held_row);
          check("hold_attn_addr", o_attn_rd_addr, held_aaddr);
          check("hold_v_addr", o_v_rd_addr, held_vaddr);
        end
        if (i_spk_ready) begin
          holding = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_row: got row %0d, expected no row", o_spk_row);
          end else begin
            e = exp_q.pop_front();
            check("row_index", o_spk_row, e.row);
            check($sformatf("row_data[%0d]", e.row), o_spk_data, e.data);
          end
        end else begin
          holding    = 1;
          held_data  = o_spk_data;
          held_row   = o_spk_row;
          held_aaddr = o_attn_rd_addr;
          held_vaddr = o_v_rd_addr;
        end
      end else begin
        holding = 0;
      end
      if (o_done) begin
        done_cnt++;
        done_seen = 1;
        check("rows_left_at_done", exp_q.size(), 0);
      end
    end
  end

  initial begin
    int k;
    s_rst    = 1'b1;
    i_start  = 1'b0;
    i_causal = 1'b0;
    i_thrd   = '0;
    repeat (3) @(posedge s_clk);
    #1;
    check("reset_busy", o_busy, 0);
    check("reset_valid", o_spk_valid, 0);
    check("reset_done", o_done, 0);
    check("reset_data", o_spk_data, 0);
    check("reset_row", o_spk_row, 0);
    check("reset_attn_addr", o_attn_rd_addr, 0);
    check("reset_v_addr", o_v_rd_addr, 0);
    s_rst = 1'b0;

    fill(0, 0); run_pass(1'b0, 1, "v_zero");
    fill(1, 1); run_pass(1'b0, 64, "ones_thr64");
    run_pass(1'b0, 100, "ones_thr100");
    run_pass(1'b1, 2, "causal_thr2");
    stall_mode = 1; stall_cnt = 0;
    run_pass(1'b0, 64, "stall_row5");
    stall_mode = 0;
    check("stall_applied", stall_cnt, 10);

    rand_ready = 1;
    fill(0, 2); run_pass(1'b0, int'($urandom_range(0, 1500)), "random_full");
    fill(0, 2); run_pass(1'b1, int'($urandom_range(0, 600)), "random_causal");
    rand_ready = 0;

    // Reset during row 30 READ, then a clean full pass
    fill(1, 1);
    start_pass(1'b0, 64);
    k = 0;
    while (exp_q.size() > N - 30 && k < 10000) begin
      @(posedge s_clk);
      k++;
    end
    checks++;
    if (exp_q.size() != N - 30) begin
      errors++;
      $display("FAIL reach_row30: got %0d rows left, expected %0d", exp_q.size(), N - 30);
    end
    repeat (5) @(posedge s_clk);
    #3 s_rst = 1'b1;
    #1;
    check("midrst_busy", o_busy, 0);
    check("midrst_valid", o_spk_valid, 0);
    check("midrst_done", o_done, 0);
    check("midrst_data", o_spk_data, 0);
    check("midrst_row", o_spk_row, 0);
    check("midrst_attn_addr", o_attn_rd_addr, 0);
    check("midrst_v_addr", o_v_rd_addr, 0);
    exp_q.delete();
    holding = 0;
    repeat (2) @(posedge s_clk);
    #1 s_rst = 1'b0;
    run_pass(1'b0, 64, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
